// File: rtl/mrb_pkg.sv
// Shared types and helpers for multi_read_bypass_ram: address/lane sizing, request struct, byte-lane merge.
package mrb_pkg;

  localparam int MRB_MAX_W  = 512;
  localparam int MRB_MAX_AW = 16;

  typedef struct packed {
    logic                  re;
    logic [MRB_MAX_AW-1:0] ra;
  } mrb_req_t;

  function automatic int mrb_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int mrb_nb(input int width, input int byte_w);
    return width / byte_w;
  endfunction

  // Callers zero-extend to MRB_MAX_W and truncate the result back to their own width.
  function automatic logic [MRB_MAX_W-1:0] merge(input logic [MRB_MAX_W-1:0] old_w,
                                                 input logic [MRB_MAX_W-1:0] new_w,
                                                 input logic [MRB_MAX_W-1:0] be,
                                                 input int                   byte_w);
    logic [MRB_MAX_W-1:0] res;
    for (int i = 0; i < MRB_MAX_W; i++) begin
      res[i] = be[i / byte_w] ? new_w[i] : old_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/mrb_rd_port.sv
// One read port: request flops, optional same-edge write bypass (MRB_WR_BYPASS_EN), optional output flop.
// Latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, a request is taken every cycle.
module mrb_rd_port
  import mrb_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int AW      = 6,
  parameter int NB      = 8,
  parameter int BYTE_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re_i,
  input  logic [AW-1:0]         ra_i,
  output logic [MRB_MAX_AW-1:0] ra_q_o,
  input  logic [WIDTH-1:0]      mem_word_i,
  input  logic                  wr_vld_i,
  input  logic [MRB_MAX_AW-1:0] wr_addr_i,
  input  logic [NB-1:0]         wr_be_i,
  input  logic [WIDTH-1:0]      wr_dat_i,
  output logic [WIDTH-1:0]      rd_o,
  output logic                  rvalid_o
);

  mrb_req_t         req_d, req_q;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] rd_d;
  logic             rvalid_d;

  always_comb begin
    req_d    = '0;
    req_d.re = re_i;
    req_d.ra = MRB_MAX_AW'(ra_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign ra_q_o = req_q.ra;

`ifdef MRB_WR_BYPASS_EN
  // The array only absorbs the write at the next edge, so a same-cycle hit takes the new lanes here.
  always_comb begin
    word = mem_word_i;
    if (wr_vld_i && (wr_addr_i == req_q.ra)) begin
      word = WIDTH'(merge(MRB_MAX_W'(mem_word_i), MRB_MAX_W'(wr_dat_i),
                          MRB_MAX_W'(wr_be_i), BYTE_W));
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_vld_i, wr_addr_i, wr_be_i, wr_dat_i};
  assign word      = mem_word_i;
`endif

  assign rd_d     = req_q.re ? word : '0;
  assign rvalid_d = req_q.re;

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] rd_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q     <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rd_q     <= rd_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rd_o     = rd_q;
    assign rvalid_o = rvalid_q;
  end else begin : g_comb
    assign rd_o     = rd_d;
    assign rvalid_o = rvalid_d;
  end

endmodule

// File: rtl/multi_read_bypass_ram.sv
// NR-read / 1-write byte-enabled RAM with registered requests; bypass build via MRB_WR_BYPASS_EN.
// Read latency 1 (+1 with OUT_REG), write visible one edge after capture; no backpressure.
module multi_read_bypass_ram
  import mrb_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int DEPTH   = 64,
  parameter  int NR      = 2,
  parameter  int BYTE_W  = 8,
  parameter  int OUT_REG = 0,
  localparam int AW      = mrb_aw(DEPTH),
  localparam int NB      = mrb_nb(WIDTH, BYTE_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR-1:0]             re,
  input  logic [NR-1:0][AW-1:0]     ra,
  output logic [NR-1:0][WIDTH-1:0]  rd,
  output logic [NR-1:0]             rvalid,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [NB-1:0]             wbe,
  input  logic [WIDTH-1:0]          wd
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        we_q;
  logic [AW-1:0]               wa_q;
  logic [NB-1:0]               wbe_q;
  logic [WIDTH-1:0]            wd_q;
  logic [MRB_MAX_AW-1:0]       wa_ext;
  logic                        wr_ok;
  logic [WIDTH-1:0]            wr_word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wbe_q <= '0;
      wd_q  <= '0;
    end else begin
      we_q  <= we;
      wa_q  <= wa;
      wbe_q <= wbe;
      wd_q  <= wd;
    end
  end

  // Out-of-range writes (non-power-of-two DEPTH) are dropped and never bypass.
  assign wa_ext = MRB_MAX_AW'(wa_q);
  assign wr_ok  = we_q && (wa_ext < MRB_MAX_AW'(DEPTH));

  always_comb begin
    wr_word_d = '0;
    if (wr_ok) begin
      wr_word_d = WIDTH'(merge(MRB_MAX_W'(mem_q[wa_q]), MRB_MAX_W'(wd_q),
                               MRB_MAX_W'(wbe_q), BYTE_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_ok) begin
      mem_q[wa_q] <= wr_word_d;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_port
    logic [MRB_MAX_AW-1:0] ra_q;
    logic [WIDTH-1:0]      word;

    assign word = (ra_q < MRB_MAX_AW'(DEPTH)) ? mem_q[ra_q[AW-1:0]] : '0;

    mrb_rd_port #(
      .WIDTH   (WIDTH),
      .AW      (AW),
      .NB      (NB),
      .BYTE_W  (BYTE_W),
      .OUT_REG (OUT_REG)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .re_i       (re[p]),
      .ra_i       (ra[p]),
      .ra_q_o     (ra_q),
      .mem_word_i (word),
      .wr_vld_i   (wr_ok),
      .wr_addr_i  (wa_ext),
      .wr_be_i    (wbe_q),
      .wr_dat_i   (wd_q),
      .rd_o       (rd[p]),
      .rvalid_o   (rvalid[p])
    );
  end

endmodule

// File: tb/tb_multi_read_bypass_ram.sv
// Directed bench for multi_read_bypass_ram (NR=2, 64x64, byte lanes); expectations follow MRB_WR_BYPASS_EN.
`timescale 1ns/1ps
module tb_multi_read_bypass_ram;

  localparam int NR      = 2;
  localparam int WIDTH   = 64;
  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int NB      = 8;
  localparam int OUT_REG = 0;
  localparam int LAT     = 1 + OUT_REG;
`ifdef MRB_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [NR-1:0]            re;
  logic [NR-1:0][AW-1:0]    ra;
  logic [NR-1:0][WIDTH-1:0] rd;
  logic [NR-1:0]            rvalid;
  logic                     we;
  logic [AW-1:0]            wa;
  logic [NB-1:0]            wbe;
  logic [WIDTH-1:0]         wd;

  multi_read_bypass_ram #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .NR      (NR),
    .BYTE_W  (8),
    .OUT_REG (OUT_REG)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .re     (re),
    .ra     (ra),
    .rd     (rd),
    .rvalid (rvalid),
    .we     (we),
    .wa     (wa),
    .wbe    (wbe),
    .wd     (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  string       tq[$];
  logic [1:0]  vq[$];
  logic [63:0] e0q[$];
  logic [63:0] e1q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then check the oldest read whose latency has elapsed.
  task automatic cyc(input string tag, input logic [1:0] r_en, input logic [5:0] a0,
                     input logic [5:0] a1, input logic w_en, input logic [5:0] waddr,
                     input logic [7:0] be, input logic [63:0] wdat,
                     input logic [63:0] e0, input logic [63:0] e1);
    string      t;
    logic [1:0] v;
    re    = r_en;
    ra[0] = a0;
    ra[1] = a1;
    we    = w_en;
    wa    = waddr;
    wbe   = be;
    wd    = wdat;
    tq.push_back(tag);
    vq.push_back(r_en);
    e0q.push_back(r_en[0] ? e0 : 64'h0);
    e1q.push_back(r_en[1] ? e1 : 64'h0);
    @(posedge clk);
    #1;
    if (vq.size() >= LAT) begin
      t = tq.pop_front();
      v = vq.pop_front();
      chk({t, "_vld"}, 64'(rvalid), 64'(v));
      chk({t, "_rd0"}, rd[0], e0q.pop_front());
      chk({t, "_rd1"}, rd[1], e1q.pop_front());
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, '0, '0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic wr(input string tag, input logic [5:0] addr, input logic [7:0] be,
                    input logic [63:0] dat);
    cyc(tag, '0, '0, '0, 1'b1, addr, be, dat, '0, '0);
  endtask

  logic [63:0] sv[5];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    re       = '0;
    ra       = '0;
    we       = 1'b0;
    wa       = '0;
    wbe      = '0;
    wd       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(rvalid), 64'h0);
    chk("rst_rd0", rd[0], 64'h0);
    chk("rst_rd1", rd[1], 64'h0);
    rst_n = 1'b1;

    // Basic full-word write, read two cycles later
    wr("wr5", 6'd5, 8'hFF, 64'h1122_3344_5566_7788);
    idle("idle_a");
    cyc("basic", 2'b01, 6'd5, 6'd0, 1'b0, '0, '0, '0, 64'h1122_3344_5566_7788, '0);

    // Back-to-back disjoint byte enables
    wr("be1", 6'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    wr("be2", 6'd3, 8'h30, 64'hAAAA_AAAA_AAAA_AAAA);
    cyc("be_rd", 2'b10, 6'd0, 6'd3, 1'b0, '0, '0, '0, '0, 64'h0000_AAAA_FFFF_FFFF);

    // Same-edge collision on both ports
    wr("pre7", 6'd7, 8'hFF, 64'h0101_0101_0101_0101);
    idle("idle_b");
    cyc("col", 2'b11, 6'd7, 6'd7, 1'b1, 6'd7, 8'hF0, 64'hEEEE_EEEE_EEEE_EEEE,
        BYP ? 64'hEEEE_EEEE_0101_0101 : 64'h0101_0101_0101_0101,
        BYP ? 64'hEEEE_EEEE_0101_0101 : 64'h0101_0101_0101_0101);
    cyc("col_nxt", 2'b11, 6'd7, 6'd7, 1'b0, '0, '0, '0,
        64'hEEEE_EEEE_0101_0101, 64'hEEEE_EEEE_0101_0101);

    // Write with no lanes enabled leaves the word alone
    wr("pre4", 6'd4, 8'hFF, 64'h4444_4444_4444_4444);
    idle("idle_c");
    cyc("iw", 2'b01, 6'd4, 6'd0, 1'b1, 6'd4, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h4444_4444_4444_4444, '0);
    cyc("iw_nxt", 2'b01, 6'd4, 6'd0, 1'b0, '0, '0, '0, 64'h4444_4444_4444_4444, '0);

    // Port 0 parked on addr 2 while writes stream into the addr port 1 reads
    sv[0] = 64'h9999_9999_9999_9999;
    sv[1] = 64'h0123_4567_89AB_CDEF;
    sv[2] = 64'hFEDC_BA98_7654_3210;
    sv[3] = 64'h5A5A_5A5A_5A5A_5A5A;
    sv[4] = 64'hA5A5_A5A5_A5A5_A5A5;
    wr("pre2", 6'd2, 8'hFF, 64'h2222_2222_2222_2222);
    wr("pre9", 6'd9, 8'hFF, sv[0]);
    for (int k = 1; k < 5; k++) begin
      cyc("mp", 2'b11, 6'd2, 6'd9, 1'b1, 6'd9, 8'hFF, sv[k],
          64'h2222_2222_2222_2222, BYP ? sv[k] : sv[k-1]);
    end
    cyc("mp_end", 2'b11, 6'd2, 6'd9, 1'b0, '0, '0, '0, 64'h2222_2222_2222_2222, sv[4]);

    // Address extremes
    wr("b63", 6'd63, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    wr("b0", 6'd0, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F);
    cyc("bnd", 2'b11, 6'd63, 6'd0, 1'b0, '0, '0, '0,
        64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_0F0F_0F0F);

    // Random fill, then reset asserted mid-read with a write still in flight
    for (int i = 0; i < 4; i++) begin
      wr("rnd", 6'(10 + i), 8'hFF, {$urandom, $urandom});
    end
    for (int i = 0; i < LAT; i++) begin
      cyc("pre_rst", 2'b11, 6'd5, 6'd3, 1'b1, 6'd20, 8'hFF, 64'h1234_1234_1234_1234,
          64'h1122_3344_5566_7788, 64'h0000_AAAA_FFFF_FFFF);
    end
    chk("pre_arst_vld", 64'(rvalid), 64'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(rvalid), 64'h0);
    chk("arst_rd0", rd[0], 64'h0);
    chk("arst_rd1", rd[1], 64'h0);
    tq.delete();
    vq.delete();
    e0q.delete();
    e1q.delete();
    re = '0;
    we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      cyc("clr", (i == 10) ? 2'b10 : 2'b11, 6'(2 * i), 6'(2 * i + 1), 1'b0, '0, '0, '0,
          '0, '0);
    end
    for (int i = 0; i < LAT; i++) begin
      idle("drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
